// File: rtl/pump_pkg.sv
// Shared state encoding, parameter defaults and bit-count/rotation helpers
// for the three-pump lead/lag sequencer.
package pump_pkg;

  localparam int STAGGER_DEF = 16;
  localparam int MIN_ON_DEF  = 32;
  localparam int MIN_OFF_DEF = 32;
  localparam int NPUMP       = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } seq_state_t;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  // Pump index at position step of the rotation starting at base (mod 3).
  function automatic logic [1:0] rot_idx(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, step};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/pump_timer.sv
// Per-pump saturating run/rest timers; both clear on the edge where the run
// command changes, so the first cycle in a new state reads zero.
module pump_timer
  import pump_pkg::*;
#(
  parameter int MIN_ON  = MIN_ON_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic run_nxt,
  output logic on_ok,
  output logic off_ok
);

  localparam int ON_W  = (MIN_ON  > 0) ? $clog2(MIN_ON  + 1) : 1;
  localparam int OFF_W = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;
  localparam logic [ON_W-1:0]  ON_MAX  = ON_W'(MIN_ON);
  localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(MIN_OFF);

  logic [ON_W-1:0]  on_cnt;
  logic [OFF_W-1:0] off_cnt;

  // Rest timer starts saturated so a freshly reset pump may start at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      on_cnt  <= '0;
      off_cnt <= OFF_MAX;
    end else if (run != run_nxt) begin
      on_cnt  <= '0;
      off_cnt <= '0;
    end else if (run) begin
      if (on_cnt != ON_MAX) on_cnt <= on_cnt + 1'b1;
    end else begin
      if (off_cnt != OFF_MAX) off_cnt <= off_cnt + 1'b1;
    end
  end

  assign on_ok  = (on_cnt == ON_MAX);
  assign off_ok = (off_cnt == OFF_MAX);

endmodule

// File: rtl/pump_sequencer.sv
// Lead/lag sequencer for three pumps: staggered starts/stops toward demand,
// minimum run/rest times, immediate drop on fault; commands appear one cycle after the decision.
module pump_sequencer
  import pump_pkg::*;
#(
  parameter int STAGGER = STAGGER_DEF,
  parameter int MIN_ON  = MIN_ON_DEF,
  parameter int MIN_OFF = MIN_OFF_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] demand,
  input  logic       alarm_req,
  input  logic [2:0] pump_fault,
  output logic [2:0] pump_on,
  output logic       alarm,
  output logic [1:0] lead,
  output logic       busy
);

  localparam int STG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [STG_W-1:0] STG_LOAD = (STAGGER > 0) ? STG_W'(STAGGER - 1) : '0;

  logic [2:0]       healthy;
  logic [2:0]       on_eff;
  logic [1:0]       avail;
  logic [1:0]       target;
  logic [1:0]       active;
  logic [1:0]       order [NPUMP];
  logic [2:0]       start_mask;
  logic [2:0]       stop_mask;
  logic             start_found;
  logic [2:0]       pump_nxt;
  logic [2:0]       on_ok;
  logic [2:0]       off_ok;
  logic [STG_W-1:0] stg;
  seq_state_t       state_q;
  seq_state_t       state_d;

  assign healthy = ~pump_fault;
  assign avail   = popcount3(healthy);
  assign target  = (demand < avail) ? demand : avail;

  // Faulted pumps are dropped this edge regardless, so they are excluded
  // from the count; otherwise a fault would also trigger a normal stop.
  assign on_eff  = pump_on & healthy;
  assign active  = popcount3(on_eff);

  always_comb begin
    for (int k = 0; k < NPUMP; k++) begin
      order[k] = rot_idx(lead, 2'(k));
    end
  end

  always_comb begin
    state_d     = ST_HOLD;
    start_mask  = '0;
    stop_mask   = '0;
    start_found = 1'b0;

    if (avail == 2'd0)        state_d = ST_IDLE;
    else if (active < target) state_d = ST_RAMP_UP;
    else if (active > target) state_d = ST_RAMP_DOWN;
    else if (active == 2'd0)  state_d = ST_IDLE;
    else                      state_d = ST_HOLD;

    if (state_d == ST_RAMP_UP && stg == '0) begin
      for (int k = 0; k < NPUMP; k++) begin
        if (!start_found && healthy[order[k]] && !pump_on[order[k]] && off_ok[order[k]]) begin
          start_mask[order[k]] = 1'b1;
          start_found          = 1'b1;
        end
      end
    end

    // Later qualifying pumps overwrite earlier ones: the last in rotation wins.
    if (state_d == ST_RAMP_DOWN && stg == '0) begin
      for (int k = 0; k < NPUMP; k++) begin
        if (on_eff[order[k]] && on_ok[order[k]]) begin
          stop_mask            = '0;
          stop_mask[order[k]]  = 1'b1;
        end
      end
    end
  end

  assign pump_nxt = (pump_on | start_mask) & ~stop_mask & healthy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pump_on <= '0;
      alarm   <= 1'b0;
      lead    <= 2'd0;
      stg     <= '0;
    end else begin
      state_q <= state_d;
      pump_on <= pump_nxt;
      alarm   <= alarm_req | (demand > avail);
      if (|start_mask || |stop_mask) begin
        stg <= STG_LOAD;
      end else if (stg != '0) begin
        stg <= stg - 1'b1;
      end
      if (|pump_on && pump_nxt == 3'b000) begin
        lead <= (lead == 2'd2) ? 2'd0 : lead + 2'd1;
      end
    end
  end

  assign busy = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

  for (genvar i = 0; i < NPUMP; i++) begin : g_tmr
    pump_timer #(
      .MIN_ON  (MIN_ON),
      .MIN_OFF (MIN_OFF)
    ) u_tmr (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (pump_on[i]),
      .run_nxt (pump_nxt[i]),
      .on_ok   (on_ok[i]),
      .off_ok  (off_ok[i])
    );
  end

endmodule

// File: tb/tb_pump_sequencer.sv
// Directed bench for pump_sequencer with STAGGER=4, MIN_ON=8, MIN_OFF=8.
module tb_pump_sequencer;

  logic       clk;
  logic       reset_n;
  logic [1:0] demand;
  logic       alarm_req;
  logic [2:0] pump_fault;
  logic [2:0] pump_on;
  logic       alarm;
  logic [1:0] lead;
  logic       busy;

  int total;
  int bad;
  logic [2:0] exp_on;

  pump_sequencer #(
    .STAGGER (4),
    .MIN_ON  (8),
    .MIN_OFF (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .demand     (demand),
    .alarm_req  (alarm_req),
    .pump_fault (pump_fault),
    .pump_on    (pump_on),
    .alarm      (alarm),
    .lead       (lead),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    tick(3);
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL reset_pump_on got=%b want=000", pump_on); end
    total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL reset_alarm got=%b want=0", alarm); end
    total++; if (lead !== 2'd0)      begin bad++; $display("FAIL reset_lead got=%0d want=0", lead); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  // Starts land 1, 5 and 9 cycles after release, one stagger apart.
  task automatic test_ramp_up();
    demand  = 2'd3;
    reset_n = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick(1);
      exp_on = (i < 5) ? 3'b001 : (i < 9) ? 3'b011 : 3'b111;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL ramp_up c%0d got=%b want=%b", i, pump_on, exp_on); end
      if (i == 5) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ramp_up_busy got=%b want=1", busy); end
      end
    end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL ramp_up_idle_busy got=%b want=0", busy); end
    total++; if (alarm !== 1'b0) begin bad++; $display("FAIL ramp_up_alarm got=%b want=0", alarm); end
    total++; if (lead !== 2'd0)  begin bad++; $display("FAIL ramp_up_lead got=%0d want=0", lead); end
  endtask

  task automatic test_ramp_down();
    tick(10);
    total++; if (pump_on !== 3'b111) begin bad++; $display("FAIL rd_hold got=%b want=111", pump_on); end
    demand = 2'd1;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      exp_on = (i < 5) ? 3'b011 : 3'b001;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL ramp_down c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ramp_down_busy got=%b want=0", busy); end
  endtask

  task automatic test_lead_rotation();
    demand = 2'd0;
    tick(1);
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL lead_stop got=%b want=000", pump_on); end
    total++; if (lead !== 2'd1)      begin bad++; $display("FAIL lead_adv got=%0d want=1", lead); end
    demand = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      exp_on = (i < 4) ? 3'b000 : 3'b010;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL lead_restart c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
  endtask

  task automatic test_fault();
    demand = 2'd3;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      exp_on = (i < 4) ? 3'b010 : (i < 8) ? 3'b110 : 3'b111;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL fault_ramp c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    tick(10);
    pump_fault = 3'b010;
    tick(1);
    total++; if (pump_on !== 3'b101) begin bad++; $display("FAIL fault_drop got=%b want=101", pump_on); end
    total++; if (alarm !== 1'b1)     begin bad++; $display("FAIL fault_alarm got=%b want=1", alarm); end
    // The forced drop must not hold off the next normal stop.
    demand = 2'd1;
    tick(1);
    total++; if (pump_on !== 3'b100) begin bad++; $display("FAIL fault_no_stagger got=%b want=100", pump_on); end
    total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL fault_alarm_clr got=%b want=0", alarm); end
  endtask

  task automatic test_min_on();
    pump_fault = 3'b000;
    demand     = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      exp_on = (i < 4) ? 3'b100 : 3'b000;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL minon_stop c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    total++; if (lead !== 2'd2) begin bad++; $display("FAIL minon_lead2 got=%0d want=2", lead); end
    // Pumps 2 and 0 are still resting; only pump 1 has served MIN_OFF.
    demand = 2'd1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      exp_on = (i < 4) ? 3'b000 : 3'b010;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL minoff_pick c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    tick(2);
    demand = 2'd0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      exp_on = (i < 7) ? 3'b010 : 3'b000;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL minon_hold c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    total++; if (lead !== 2'd0) begin bad++; $display("FAIL minon_lead_wrap got=%0d want=0", lead); end
  endtask

  task automatic test_all_fault_and_reset();
    demand = 2'd2;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      exp_on = (i < 4) ? 3'b000 : (i < 8) ? 3'b001 : 3'b101;
      total++; if (pump_on !== exp_on) begin bad++; $display("FAIL af_ramp c%0d got=%b want=%b", i, pump_on, exp_on); end
    end
    pump_fault = 3'b111;
    tick(1);
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL af_drop got=%b want=000", pump_on); end
    total++; if (alarm !== 1'b1)     begin bad++; $display("FAIL af_alarm got=%b want=1", alarm); end
    total++; if (lead !== 2'd1)      begin bad++; $display("FAIL af_lead got=%0d want=1", lead); end
    tick(1);
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL af_stay got=%b want=000", pump_on); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL af_idle got=%b want=0", busy); end
    pump_fault = 3'b000;
    demand     = 2'd3;
    alarm_req  = 1'b1;
    tick(1);
    total++; if (alarm !== 1'b1)     begin bad++; $display("FAIL alarm_req got=%b want=1", alarm); end
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL rst_pre_wait got=%b want=000", pump_on); end
    tick(1);
    total++; if (pump_on !== 3'b010) begin bad++; $display("FAIL rst_pre_start got=%b want=010", pump_on); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL rst_pre_busy got=%b want=1", busy); end
    reset_n = 1'b0;
    #1;
    total++; if (pump_on !== 3'b000) begin bad++; $display("FAIL rst_async_pump got=%b want=000", pump_on); end
    total++; if (alarm !== 1'b0)     begin bad++; $display("FAIL rst_async_alarm got=%b want=0", alarm); end
    total++; if (lead !== 2'd0)      begin bad++; $display("FAIL rst_async_lead got=%0d want=0", lead); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_async_busy got=%b want=0", busy); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    exp_on     = 3'b000;
    reset_n    = 1'b0;
    demand     = 2'd0;
    alarm_req  = 1'b0;
    pump_fault = 3'b000;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_lead_rotation();
    test_fault();
    test_min_on();
    test_all_fault_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
